// File: rtl/ipsmacge_rxctl_pkg.sv
// Shared receive-control definitions (ipsmacge_rxctl_def): state encodings,
// framer error-bit positions and default sizing.
package ipsmacge_rxctl_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int DRN_MAX_DEF = 2047;

    localparam int ERR_FCS = 0;
    localparam int ERR_PRM = 1;
    localparam int ERR_RCV = 2;
    localparam int ERR_GAP = 3;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_WIDLE = 2'b01,
        ST_ON    = 2'b10,
        ST_DRAIN = 2'b11
    } rx_st_e;

    function automatic logic [4:0] idle_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/ipsmacge_satcnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ipsmacge_satcnt #(
    parameter int WIDTH = 16
) (
    input  logic             rxclk,
    input  logic             rst_,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge rxclk or negedge rst_) begin
        if (!rst_)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + WIDTH'(1);
    end

endmodule

// File: rtl/ipsmacge_rxctl.sv
// MAC receive enable/drain controller with frame status counters.
// Counters are built only when IPSMACGE_RXCTL_CNT_EN is defined.
module ipsmacge_rxctl
    import ipsmacge_rxctl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DRN_MAX = DRN_MAX_DEF
) (
    input  logic             rxclk,
    input  logic             rst_,
    input  logic             cpu_rxen,
    input  logic [3:0]       cpu_thidle,
    input  logic             cpu_cntclr,
    input  logic             igval,
    input  logic             igdv,
    input  logic             fr_sop,
    input  logic             fr_eop,
    input  logic [3:0]       fr_err,
    output logic             up_rxen,
    output logic             up_act,
    output logic [1:0]       rx_stt,
    output logic             rx_drop,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_fcs,
    output logic [CNT_W-1:0] cnt_oerr
);

    localparam int              DRN_W   = $clog2(DRN_MAX + 1);
    localparam logic [DRN_W-1:0] DRN_LIM = DRN_W'(DRN_MAX);

    rx_st_e           st;
    logic [4:0]       idle_cnt;
    logic [DRN_W-1:0] drn_cnt;
    logic [DRN_W-1:0] drn_nxt;
    logic             drn_tmo;
    logic             inframe;
    logic             inframe_nxt;

    always_comb begin
        drn_nxt     = drn_cnt + DRN_W'(igval);
        drn_tmo     = (drn_nxt == DRN_LIM);
        inframe_nxt = fr_eop ? 1'b0 : (fr_sop ? 1'b1 : inframe);
    end

    always_ff @(posedge rxclk or negedge rst_) begin
        if (!rst_) begin
            st       <= ST_OFF;
            idle_cnt <= '0;
            drn_cnt  <= '0;
            inframe  <= 1'b0;
        end else begin
            case (st)
                ST_OFF: begin
                    idle_cnt <= '0;
                    drn_cnt  <= '0;
                    inframe  <= 1'b0;
                    if (cpu_rxen)
                        st <= ST_WIDLE;
                end
                ST_WIDLE: begin
                    inframe <= 1'b0;
                    if (!cpu_rxen)
                        st <= ST_OFF;
                    else if (idle_cnt >= {1'b0, cpu_thidle})
                        st <= ST_ON;
                    // Any active rx_dv breaks the run of idle cycles.
                    if (igval)
                        idle_cnt <= igdv ? 5'd0 : idle_inc(idle_cnt);
                end
                ST_ON: begin
                    inframe <= inframe_nxt;
                    if (!cpu_rxen) begin
                        drn_cnt <= '0;
                        if (inframe) begin
                            st <= ST_DRAIN;
                        end else begin
                            st      <= ST_OFF;
                            inframe <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    inframe <= inframe_nxt;
                    if (fr_eop) begin
                        st <= ST_OFF;
                    end else if (drn_tmo) begin
                        st      <= ST_OFF;
                        inframe <= 1'b0;
                    end else if (cpu_rxen) begin
                        st      <= ST_ON;
                        drn_cnt <= '0;
                    end else begin
                        drn_cnt <= drn_nxt;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge rxclk or negedge rst_) begin
        if (!rst_)
            rx_drop <= 1'b0;
        else if (cpu_cntclr)
            rx_drop <= 1'b0;
        else if (st == ST_DRAIN && !fr_eop && drn_tmo)
            rx_drop <= 1'b1;
    end

    assign rx_stt  = st;
    assign up_rxen = st[1];
    assign up_act  = st[1];

    logic inc_good;
    logic inc_fcs;
    logic inc_oerr;
    logic cnt_clr;

`ifdef IPSMACGE_RXCTL_CNT_EN
    assign inc_good = st[1] & fr_eop & (fr_err == 4'd0);
    assign inc_fcs  = st[1] & fr_eop & fr_err[ERR_FCS];
    assign inc_oerr = st[1] & fr_eop & (fr_err[ERR_GAP] | fr_err[ERR_RCV] | fr_err[ERR_PRM]);
    assign cnt_clr  = cpu_cntclr;
`else
    // Counters held in clear so they read constant zero.
    logic cnt_unused;
    assign cnt_unused = ^fr_err;
    assign inc_good   = 1'b0;
    assign inc_fcs    = 1'b0;
    assign inc_oerr   = 1'b0;
    assign cnt_clr    = 1'b1;
`endif

    ipsmacge_satcnt #(.WIDTH(CNT_W)) u_cnt_good (
        .rxclk (rxclk),
        .rst_  (rst_),
        .clr   (cnt_clr),
        .inc   (inc_good),
        .cnt   (cnt_good)
    );

    ipsmacge_satcnt #(.WIDTH(CNT_W)) u_cnt_fcs (
        .rxclk (rxclk),
        .rst_  (rst_),
        .clr   (cnt_clr),
        .inc   (inc_fcs),
        .cnt   (cnt_fcs)
    );

    ipsmacge_satcnt #(.WIDTH(CNT_W)) u_cnt_oerr (
        .rxclk (rxclk),
        .rst_  (rst_),
        .clr   (cnt_clr),
        .inc   (inc_oerr),
        .cnt   (cnt_oerr)
    );

endmodule

// File: tb/tb_ipsmacge_rxctl.sv
// Directed bench for ipsmacge_rxctl with a cycle model checked every negedge.
module tb_ipsmacge_rxctl;

    localparam int CW   = 4;
    localparam int DM   = 8;
    localparam int CMAX = 15;
`ifdef IPSMACGE_RXCTL_CNT_EN
    localparam int CEN = 1;
`else
    localparam int CEN = 0;
`endif

    logic          rxclk = 1'b0;
    logic          rst_  = 1'b1;
    logic          cpu_rxen = 1'b0;
    logic [3:0]    cpu_thidle = 4'd4;
    logic          cpu_cntclr = 1'b0;
    logic          igval = 1'b0;
    logic          igdv = 1'b0;
    logic          fr_sop = 1'b0;
    logic          fr_eop = 1'b0;
    logic [3:0]    fr_err = 4'd0;
    logic          up_rxen;
    logic          up_act;
    logic [1:0]    rx_stt;
    logic          rx_drop;
    logic [CW-1:0] cnt_good;
    logic [CW-1:0] cnt_fcs;
    logic [CW-1:0] cnt_oerr;

    int errs   = 0;
    int checks = 0;

    ipsmacge_rxctl #(.CNT_W(CW), .DRN_MAX(DM)) dut (
        .rxclk      (rxclk),
        .rst_       (rst_),
        .cpu_rxen   (cpu_rxen),
        .cpu_thidle (cpu_thidle),
        .cpu_cntclr (cpu_cntclr),
        .igval      (igval),
        .igdv       (igdv),
        .fr_sop     (fr_sop),
        .fr_eop     (fr_eop),
        .fr_err     (fr_err),
        .up_rxen    (up_rxen),
        .up_act     (up_act),
        .rx_stt     (rx_stt),
        .rx_drop    (rx_drop),
        .cnt_good   (cnt_good),
        .cnt_fcs    (cnt_fcs),
        .cnt_oerr   (cnt_oerr)
    );

    always #5 rxclk = ~rxclk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // mode: 0 off, 1 waiting for idle, 2 receiving, 3 draining
    typedef struct {
        int mode;
        int idle;
        int drn;
        int inf;
        int drop;
        int good;
        int fcs;
        int oerr;
    } mst_t;

    mst_t m = '{default: 0};

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic mst_t step(input mst_t c);
        mst_t n;
        int   active;
        int   tmo;
        n      = c;
        active = (c.mode >= 2);
        tmo    = 0;
        if (c.mode == 0) begin
            n.idle = 0;
            if (cpu_rxen) n.mode = 1;
        end else if (c.mode == 1) begin
            if (!cpu_rxen) n.mode = 0;
            else if (c.idle >= int'(cpu_thidle)) n.mode = 2;
            if (igval) n.idle = igdv ? 0 : sat(c.idle + 1, 31);
        end else if (c.mode == 2) begin
            if (!cpu_rxen) begin
                n.drn  = 0;
                n.mode = (c.inf != 0) ? 3 : 0;
            end
        end else begin
            if (fr_eop) n.mode = 0;
            else if (c.drn + int'(igval) >= DM) begin
                n.mode = 0;
                tmo    = 1;
            end else if (cpu_rxen) begin
                n.mode = 2;
                n.drn  = 0;
            end else n.drn = c.drn + int'(igval);
        end
        n.inf = active ? (fr_eop ? 0 : (fr_sop ? 1 : c.inf)) : 0;
        if (cpu_cntclr) begin
            n.drop = 0;
            n.good = 0;
            n.fcs  = 0;
            n.oerr = 0;
        end else begin
            if (tmo) n.drop = 1;
            if (CEN != 0 && active && fr_eop) begin
                if (fr_err == 4'd0) n.good = sat(c.good + 1, CMAX);
                if (fr_err[0])      n.fcs  = sat(c.fcs + 1, CMAX);
                if (fr_err[3:1] != 3'd0) n.oerr = sat(c.oerr + 1, CMAX);
            end
        end
        return n;
    endfunction

    initial forever begin
        @(posedge rxclk or negedge rst_);
        if (!rst_) m = '{default: 0};
        else m = step(m);
    end

    initial forever begin
        @(negedge rxclk);
        chk("m_stt",  int'(rx_stt),   m.mode);
        chk("m_rxen", int'(up_rxen),  int'(m.mode >= 2));
        chk("m_act",  int'(up_act),   int'(m.mode >= 2));
        chk("m_drop", int'(rx_drop),  m.drop);
        chk("m_good", int'(cnt_good), m.good);
        chk("m_fcs",  int'(cnt_fcs),  m.fcs);
        chk("m_oerr", int'(cnt_oerr), m.oerr);
    end

    task automatic tick();
        @(posedge rxclk);
        #2;
    endtask

    task automatic wait_st(input int s, input string nm);
        int n = 0;
        while (int'(rx_stt) != s && n < 30) begin
            tick();
            n++;
        end
        chk(nm, int'(rx_stt), s);
    endtask

    initial begin
        #1 rst_ = 1'b0;
        #1;
        chk("rst_stt",  int'(rx_stt),   0);
        chk("rst_rxen", int'(up_rxen),  0);
        chk("rst_act",  int'(up_act),   0);
        chk("rst_drop", int'(rx_drop),  0);
        chk("rst_good", int'(cnt_good), 0);
        tick();
        tick();
        rst_ = 1'b1;

        // Idle qualification: toggling rx_dv never accumulates 4 idle cycles
        cpu_rxen = 1'b1;
        igval    = 1'b1;
        igdv     = 1'b1;
        tick();
        chk("idle_entry", int'(rx_stt), 1);
        for (int i = 0; i < 12; i++) begin
            igdv = 1'((i >> 1) & 1);
            tick();
            chk("idle_toggle", int'(rx_stt), 1);
        end
        igdv = 1'b0;
        repeat (4) tick();
        chk("idle_4th_stt",  int'(rx_stt),  1);
        chk("idle_4th_rxen", int'(up_rxen), 0);
        tick();
        chk("idle_on_stt",  int'(rx_stt),  2);
        chk("idle_on_rxen", int'(up_rxen), 1);
        chk("idle_on_act",  int'(up_act),  1);

        // Disable mid-frame: drain until the frame closes
        igval  = 1'b0;
        fr_sop = 1'b1;
        tick();
        fr_sop   = 1'b0;
        cpu_rxen = 1'b0;
        tick();
        chk("drn_entry", int'(rx_stt), 3);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("drn_hold", int'(rx_stt), 3);
        end
        fr_eop = 1'b1;
        tick();
        fr_eop = 1'b0;
        chk("drn_off",  int'(rx_stt),   0);
        chk("drn_good", int'(cnt_good), CEN);

        // Drain timeout after DM valid cycles
        cpu_rxen = 1'b1;
        igval    = 1'b1;
        wait_st(2, "tmo_on");
        fr_sop = 1'b1;
        tick();
        fr_sop   = 1'b0;
        cpu_rxen = 1'b0;
        tick();
        chk("tmo_drain", int'(rx_stt), 3);
        repeat (7) tick();
        chk("tmo_7_stt",  int'(rx_stt),  3);
        chk("tmo_7_drop", int'(rx_drop), 0);
        tick();
        chk("tmo_8_stt",  int'(rx_stt),  0);
        chk("tmo_8_drop", int'(rx_drop), 1);
        cpu_cntclr = 1'b1;
        tick();
        cpu_cntclr = 1'b0;
        chk("tmo_clr_drop", int'(rx_drop),  0);
        chk("tmo_clr_good", int'(cnt_good), 0);

        // Saturation with errored frames
        cpu_rxen = 1'b1;
        wait_st(2, "sat_on");
        igval = 1'b0;
        for (int f = 0; f < 17; f++) begin
            fr_sop = 1'b1;
            tick();
            fr_sop = 1'b0;
            fr_eop = 1'b1;
            fr_err = 4'b1001;
            tick();
            fr_eop = 1'b0;
            fr_err = 4'd0;
        end
        chk("sat_fcs",  int'(cnt_fcs),  CEN * 15);
        chk("sat_oerr", int'(cnt_oerr), CEN * 15);
        chk("sat_good", int'(cnt_good), 0);
        cpu_cntclr = 1'b1;
        fr_eop     = 1'b1;
        tick();
        cpu_cntclr = 1'b0;
        chk("clr_good", int'(cnt_good), 0);
        chk("clr_fcs",  int'(cnt_fcs),  0);
        chk("clr_oerr", int'(cnt_oerr), 0);
        fr_err = 4'b0100;
        tick();
        chk("rcv_oerr", int'(cnt_oerr), CEN);
        fr_err = 4'd0;
        tick();
        fr_eop = 1'b0;
        chk("good_one", int'(cnt_good), CEN);

        // Re-enable from drain, then reset mid-frame
        fr_sop = 1'b1;
        tick();
        fr_sop   = 1'b0;
        cpu_rxen = 1'b0;
        tick();
        chk("rs_drain", int'(rx_stt), 3);
        cpu_rxen = 1'b1;
        tick();
        chk("rs_back_on", int'(rx_stt), 2);
        cpu_rxen = 1'b0;
        tick();
        chk("rs_drain2", int'(rx_stt), 3);
        #1 rst_ = 1'b0;
        #1;
        chk("arst_stt",  int'(rx_stt),   0);
        chk("arst_rxen", int'(up_rxen),  0);
        chk("arst_act",  int'(up_act),   0);
        chk("arst_drop", int'(rx_drop),  0);
        chk("arst_good", int'(cnt_good), 0);
        chk("arst_oerr", int'(cnt_oerr), 0);
        cpu_rxen = 1'b1;
        tick();
        rst_ = 1'b1;
        tick();
        chk("rel_widle", int'(rx_stt), 1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d", errs, checks);
        $fatal(1);
    end

endmodule
